// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bus for alu_issue_ctrl.
// ALU_ISSUE_STICKY_OVF_EN adds the sticky-overflow signals.
interface alu_issue_ctrl_if;
  logic       inValid;
  logic       inReady;
  logic       inLoad;
  logic [3:0] inImm;
  logic [2:0] inMode;
  logic [1:0] inSrcA;
  logic [1:0] inSrcB;
  logic [1:0] inDst;
  logic       inUseCarry;
  logic [3:0] aluA;
  logic [3:0] aluB;
  logic       aluC;
  logic [2:0] aluMode;
  logic [3:0] aluR;
  logic       aluOvf;
  logic       outValid;
  logic       outReady;
  logic [3:0] outR;
  logic       outOvf;
`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic       ovfSticky;
  logic       clrSticky;
`endif

  modport slave (
    input  inValid, inLoad, inImm, inMode, inSrcA, inSrcB, inDst, inUseCarry,
    input  aluR, aluOvf, outReady,
`ifdef ALU_ISSUE_STICKY_OVF_EN
    input  clrSticky,
    output ovfSticky,
`endif
    output inReady, aluA, aluB, aluC, aluMode, outValid, outR, outOvf
  );

  modport master (
    output inValid, inLoad, inImm, inMode, inSrcA, inSrcB, inDst, inUseCarry,
    output aluR, aluOvf, outReady,
`ifdef ALU_ISSUE_STICKY_OVF_EN
    output clrSticky,
    input  ovfSticky,
`endif
    input  inReady, aluA, aluB, aluC, aluMode, outValid, outR, outOvf
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand-issue / result-capture stage for a 4-bit combinational ALU.
// Optional sticky overflow flag enabled by ALU_ISSUE_STICKY_OVF_EN.
module alu_issue_ctrl #(
  parameter int unsigned NREG = 4
) (
  input logic              clk,
  input logic              rstN,
  alu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] rf [NREG];
  logic       c_flag;
  logic [1:0] dst_q;
  logic [3:0] alu_a_q, alu_b_q, out_r_q;
  logic       alu_c_q, out_ovf_q;
  logic [2:0] alu_mode_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.inValid) state_d = bus.inLoad ? HOLD : ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (bus.outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      c_flag     <= 1'b0;
      dst_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= 1'b0;
      alu_mode_q <= '0;
      out_r_q    <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.inValid) begin
            if (bus.inLoad) begin
              rf[bus.inDst] <= bus.inImm;
              out_r_q       <= bus.inImm;
              out_ovf_q     <= 1'b0;
            end else begin
              alu_a_q    <= rf[bus.inSrcA];
              alu_b_q    <= rf[bus.inSrcB];
              alu_c_q    <= bus.inUseCarry & c_flag;
              alu_mode_q <= bus.inMode;
              dst_q      <= bus.inDst;
            end
          end
        end
        ISSUE: begin
          rf[dst_q] <= bus.aluR;
          c_flag    <= bus.aluOvf;
          out_r_q   <= bus.aluR;
          out_ovf_q <= bus.aluOvf;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic sticky_q;

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                             sticky_q <= 1'b0;
    else if (state_q == ISSUE && bus.aluOvf) sticky_q <= 1'b1;
    else if (bus.clrSticky)                sticky_q <= 1'b0;
  end

  assign bus.ovfSticky = sticky_q;
`endif

  assign bus.inReady  = (state_q == IDLE);
  assign bus.outValid = (state_q == HOLD);
  assign bus.aluA     = alu_a_q;
  assign bus.aluB     = alu_b_q;
  assign bus.aluC     = alu_c_q;
  assign bus.aluMode  = alu_mode_q;
  assign bus.outR     = out_r_q;
  assign bus.outOvf   = out_ovf_q;

endmodule
